// File: rtl/store_buffer.sv
// Store path for the data-memory interface: alignment check, lane byte-enable and data
// replication, a DEPTH-entry FIFO drained over req/ack, and load-vs-pending-store detection.
module store_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [1:0]               st_size,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ades,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W/8-1:0]      mem_be,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_conflict,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [BE_W-1:0]   be_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [OFF_W-1:0]  lane;
    logic              word_sel;
    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [ADDR_W-1:0] addr_c;
    logic              misalign;
    logic              push;
    logic              pop;
    logic              unused_ld_low;

    assign lane     = st_addr[OFF_W-1:0];
    // Upper-word select only exists on a 64-bit bus.
    assign word_sel = (DATA_W == 64) ? st_addr[2] : 1'b0;
    assign addr_c   = {st_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign unused_ld_low = ^ld_addr[OFF_W-1:0];

    always_comb begin
        be_c    = '0;
        wdata_c = '0;
        case (st_size)
            2'b00: begin
                be_c    = BE_W'(1) << lane;
                wdata_c = {(DATA_W/8){st_data[7:0]}};
            end
            2'b01: begin
                be_c    = BE_W'(2'b11) << lane;
                wdata_c = {(DATA_W/16){st_data[15:0]}};
            end
            2'b10: begin
                be_c    = BE_W'(4'hF) << {word_sel, 2'b00};
                wdata_c = {(DATA_W/32){st_data[31:0]}};
            end
            default: begin
                be_c    = '1;
                wdata_c = st_data;
            end
        endcase
    end

    always_comb begin
        misalign = 1'b0;
        case (st_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = st_addr[0];
            2'b10:   misalign = |st_addr[1:0];
            default: misalign = (DATA_W != 64) || (|st_addr[2:0]);
        endcase
    end

    assign st_ades  = st_valid && misalign;
    assign st_ready = (count_q != FULL) && !rst;
    assign mem_req  = (count_q != '0);
    assign push     = st_valid && st_ready && !st_ades;
    assign pop      = mem_req && mem_ack;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
    end

    always_comb begin
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        if (mem_req) begin
            mem_addr  = addr_q[head_q];
            mem_be    = be_q[head_q];
            mem_wdata = data_q[head_q];
        end
    end

    // Entry i is live when its distance from the head is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] rel;
        rel         = '0;
        ld_conflict = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rel = PTR_W'(i) - head_q;
            if (({1'b0, rel} < count_q) &&
                (addr_q[i][ADDR_W-1:OFF_W] == ld_addr[ADDR_W-1:OFF_W])) begin
                ld_conflict = 1'b1;
            end
        end
    end

    assign count = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                be_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                addr_q[tail_q] <= addr_c;
                be_q[tail_q]   <= be_c;
                data_q[tail_q] <= wdata_c;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer (DATA_W=32, DEPTH=4): expected drains are queued at
// drive time and compared when the DUT completes a req/ack handshake.
module tb_store_buffer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              st_valid;
    logic              st_ready;
    logic [1:0]        st_size;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ades;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_conflict;
    logic [2:0]        count;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    store_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size),
        .st_addr(st_addr), .st_data(st_data), .st_ades(st_ades), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict), .count(count)
    );

    always #5 clk = ~clk;

    // Drain monitor: every completed handshake must match the oldest expected store.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && mem_req && mem_ack) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL drain_unexpected: got addr=%h be=%b data=%h, required no entry",
                         mem_addr, mem_be, mem_wdata);
            end else begin
                e = sb_q.pop_front();
                if ({mem_addr, mem_be, mem_wdata} !== e) begin
                    n_err++;
                    $display("FAIL drain_entry: got addr=%h be=%b data=%h, required addr=%h be=%b data=%h",
                             mem_addr, mem_be, mem_wdata, e.addr, e.be, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_size  = sz;
        st_addr  = a;
        st_data  = d;
    endtask

    task automatic drain();
        mem_ack = 1'b1;
        for (int i = 0; i < 20 && count != 0; i++) tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; st_valid = 1'b0; st_size = 2'b00; st_addr = '0; st_data = '0;
        mem_ack = 1'b0; ld_addr = '0;
        tick(); tick();
        @(negedge clk);
        n_cmp++;
        if ({st_ready, mem_req, count, ld_conflict} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got ready=%b req=%b count=%0d conflict=%b, required all 0",
                     st_ready, mem_req, count, ld_conflict);
        end
        n_cmp++;
        if ({mem_addr, mem_be, mem_wdata} !== 68'b0) begin
            n_err++;
            $display("FAIL reset_head: got addr=%h be=%b data=%h, required 0",
                     mem_addr, mem_be, mem_wdata);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (st_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b, required 1", st_ready);
        end
    endtask

    task automatic test_byte_lanes();
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            drive_store(2'b00, 32'h100 + 32'(i), 32'h0000_00AB);
            sb_q.push_back('{addr: 32'h100, be: 4'b0001 << i, data: 32'hABAB_ABAB});
        end
        tick();
        st_valid = 1'b0;
        tick(); tick();
        mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (count !== 3'd0 || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL byte_lanes_drained: got count=%0d pending=%0d, required 0/0",
                     count, sb_q.size());
        end
    endtask

    task automatic test_half_ades();
        mem_ack = 1'b0;
        tick();
        drive_store(2'b01, 32'h202, 32'h0000_1234);
        sb_q.push_back('{addr: 32'h200, be: 4'b1100, data: 32'h1234_1234});
        @(negedge clk);
        n_cmp++;
        if (st_ades !== 1'b0) begin
            n_err++;
            $display("FAIL sh_aligned_ades: got %b, required 0", st_ades);
        end
        tick();
        drive_store(2'b01, 32'h201, 32'h0000_5678);
        @(negedge clk);
        n_cmp++;
        if (st_ades !== 1'b1 || count !== 3'd1) begin
            n_err++;
            $display("FAIL sh_misaligned: got ades=%b count=%0d, required 1/1", st_ades, count);
        end
        tick();
        drive_store(2'b10, 32'h302, 32'hDEAD_BEEF);
        @(negedge clk);
        n_cmp++;
        if (st_ades !== 1'b1) begin
            n_err++;
            $display("FAIL sw_misaligned: got ades=%b, required 1", st_ades);
        end
        tick();
        drive_store(2'b11, 32'h300, 32'hDEAD_BEEF);
        @(negedge clk);
        n_cmp++;
        if (st_ades !== 1'b1) begin
            n_err++;
            $display("FAIL sd_illegal_32: got ades=%b, required 1", st_ades);
        end
        tick();
        st_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (count !== 3'd1 || st_ades !== 1'b0) begin
            n_err++;
            $display("FAIL ades_not_enqueued: got count=%0d ades=%b, required 1/0", count, st_ades);
        end
        drain();
    endtask

    task automatic test_full();
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            drive_store(2'b10, 32'h500 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            if (i < 4) sb_q.push_back('{addr: 32'h500 + 32'(4 * i), be: 4'hF,
                                        data: 32'hC0DE_0000 + 32'(i)});
            @(negedge clk);
            n_cmp++;
            if (st_ready !== (i < 4)) begin
                n_err++;
                $display("FAIL full_ready[%0d]: got %b, required %b", i, st_ready, i < 4);
            end
        end
        n_cmp++;
        if (count !== 3'd4) begin
            n_err++;
            $display("FAIL full_count: got %0d, required 4", count);
        end
        tick();
        mem_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (st_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready_during_ack: got %b, required 0", st_ready);
        end
        tick();
        st_valid = 1'b0;
        mem_ack  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (count !== 3'd3 || st_ready !== 1'b1) begin
            n_err++;
            $display("FAIL full_after_pop: got count=%0d ready=%b, required 3/1", count, st_ready);
        end
        drain();
    endtask

    task automatic test_wrap();
        int          sent = 0;
        int          off;
        logic [31:0] d;
        for (int cyc = 0; cyc < 200; cyc++) begin
            tick();
            if (sent == 10 && count == 0) break;
            mem_ack = (cyc % 2 == 0);
            if (sent < 10 && st_ready) begin
                d = $urandom;
                case (sent % 3)
                    0: begin
                        off = sent % 4;
                        drive_store(2'b00, 32'h600 + 32'(8 * sent + off), d);
                        sb_q.push_back('{addr: 32'h600 + 32'(8 * sent), be: 4'b0001 << off,
                                         data: {4{d[7:0]}}});
                    end
                    1: begin
                        off = 2 * (sent % 2);
                        drive_store(2'b01, 32'h600 + 32'(8 * sent + off), d);
                        sb_q.push_back('{addr: 32'h600 + 32'(8 * sent), be: 4'b0011 << off,
                                         data: {2{d[15:0]}}});
                    end
                    default: begin
                        drive_store(2'b10, 32'h600 + 32'(8 * sent), d);
                        sb_q.push_back('{addr: 32'h600 + 32'(8 * sent), be: 4'hF, data: d});
                    end
                endcase
                sent++;
            end else begin
                st_valid = 1'b0;
            end
        end
        st_valid = 1'b0;
        mem_ack  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (sent != 10 || count !== 3'd0 || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL wrap_complete: got sent=%0d count=%0d pending=%0d, required 10/0/0",
                     sent, count, sb_q.size());
        end
    endtask

    task automatic test_conflict();
        mem_ack = 1'b0;
        tick();
        drive_store(2'b10, 32'h400, 32'h1111_2222);
        ld_addr = 32'h400;
        sb_q.push_back('{addr: 32'h400, be: 4'hF, data: 32'h1111_2222});
        @(negedge clk);
        n_cmp++;
        if (ld_conflict !== 1'b0) begin
            n_err++;
            $display("FAIL conflict_same_cycle: got %b, required 0", ld_conflict);
        end
        tick();
        st_valid = 1'b0;
        ld_addr  = 32'h402;
        @(negedge clk);
        n_cmp++;
        if (ld_conflict !== 1'b1) begin
            n_err++;
            $display("FAIL conflict_hit_0x402: got %b, required 1", ld_conflict);
        end
        ld_addr = 32'h404;
        #1;
        n_cmp++;
        if (ld_conflict !== 1'b0) begin
            n_err++;
            $display("FAIL conflict_miss_0x404: got %b, required 0", ld_conflict);
        end
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        ld_addr = 32'h402;
        @(negedge clk);
        n_cmp++;
        if (ld_conflict !== 1'b0) begin
            n_err++;
            $display("FAIL conflict_after_ack: got %b, required 0", ld_conflict);
        end
    endtask

    task automatic test_reset_mid();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            drive_store(2'b10, 32'h700 + 32'(4 * i), 32'hBAD0_0000 + 32'(i));
        end
        tick();
        st_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (count !== 3'd3 || mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_fill: got count=%0d req=%b, required 3/1", count, mem_req);
        end
        tick();
        mem_ack = 1'b1;
        rst     = 1'b1;
        #1;
        n_cmp++;
        if ({mem_req, count, st_ready} !== 5'b0) begin
            n_err++;
            $display("FAIL async_reset: got req=%b count=%0d ready=%b, required 0/0/0",
                     mem_req, count, st_ready);
        end
        mem_ack = 1'b0;
        tick();
        rst     = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_req !== 1'b0 || st_ready !== 1'b1) begin
                n_err++;
                $display("FAIL post_reset_empty[%0d]: got req=%b ready=%b, required 0/1",
                         i, mem_req, st_ready);
            end
            tick();
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_half_ades();
        test_full();
        test_wrap();
        test_conflict();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
